// File: rtl/multi_port_memory_controller_pkg.sv
// Shared constants for the multi-port memory controller: transfer size codes,
// FSM state encodings and the default IO region selector.
package multi_port_memory_controller_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_XFER = 2'd1;
  localparam logic [1:0] MC_WAIT = 2'd2;
  localparam logic [1:0] MC_DONE = 2'd3;

  // Value of addr[17:16] that selects the UART/IO region.
  localparam logic [1:0] MC_IO_HI = 2'b11;

  // Index of the last byte of a transfer; the illegal size 3 behaves as a word.
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: last_byte = 2'd0;
      MEM_SIZE_H: last_byte = 2'd1;
      default:    last_byte = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/multi_port_memory_controller_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible channel at or after rr_ptr.
module multi_port_memory_controller_rr_arbiter #(
  parameter int unsigned NCH = 3,
  parameter int unsigned PW  = 2
) (
  input  logic [NCH-1:0] eligible,
  input  logic [PW-1:0]  rr_ptr,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  grant_idx,
  output logic           valid
);

  int unsigned    idx;
  logic [NCH-1:0] rot;

  // Scan from the farthest offset back towards rr_ptr so the nearest eligible channel wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    rot       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (32'(rr_ptr) + NCH - 1 - k) % NCH;
      rot = eligible >> idx;
      if (rot[0]) begin
        grant     = NCH'(1) << idx;
        grant_idx = PW'(idx);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_memory_controller.sv
// Multi-channel memory controller: round-robin arbitration over NCH request
// channels onto a byte-serial RAM/UART bus, with 1/2/4-byte transfers,
// read sign/zero extension, flush cancellation and IO write throttling.
module multi_port_memory_controller
  import multi_port_memory_controller_pkg::*;
#(
  parameter int unsigned NCH   = 3,
  parameter int unsigned XLEN  = 32,
  parameter logic [1:0]  IO_HI = MC_IO_HI
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                io_buffer_full,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH-1:0]      req_keep,
  input  logic [NCH-1:0]      req_we,
  input  logic [2*NCH-1:0]    req_size,
  input  logic [NCH-1:0]      req_signed,
  input  logic [XLEN*NCH-1:0] req_addr,
  input  logic [XLEN*NCH-1:0] req_wdata,
  output logic [NCH-1:0]      req_ready,
  output logic [NCH-1:0]      resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic                busy,
  input  logic [7:0]          ram_din,
  output logic [7:0]          ram_dout,
  output logic [XLEN-1:0]     ram_addr,
  output logic                ram_wr
);

  localparam int unsigned PW = $clog2(NCH);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, ch_q;
  logic            we_q, keep_q, signed_q, cap_pend_q;
  logic [1:0]      size_q, cnt_q, cnt_d, cap_idx_q;
  logic [XLEN-1:0] addr_q, wdata_q, data_q, ext;
  logic [NCH-1:0]  eligible, arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_valid, go, cancel, issue, resp_fire, last, io_hit;

  // A channel competes unless flushed without keep or writing to a full UART.
  always_comb begin
    eligible = '0;
    io_hit   = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      io_hit      = (req_addr[c*XLEN+16 +: 2] == IO_HI);
      eligible[c] = req_valid[c] & ~(flush & ~req_keep[c])
                  & ~(req_we[c] & io_buffer_full & io_hit);
    end
  end

  multi_port_memory_controller_rr_arbiter #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign go        = (state_q == MC_IDLE) && rdy && arb_valid;
  assign req_ready = go ? arb_grant : '0;
  // Only speculative reads can be cancelled; stores and committed requests run to completion.
  assign cancel    = flush && !keep_q && !we_q && (state_q != MC_IDLE);
  assign issue     = (state_q == MC_XFER) && rdy && !cancel;
  assign resp_fire = (state_q == MC_DONE) && rdy && !cancel;
  assign last      = (cnt_q == last_byte(size_q));
  assign busy      = (state_q != MC_IDLE);

  assign ram_addr   = issue ? addr_q + XLEN'(cnt_q) : '0;
  assign ram_wr     = issue && we_q;
  assign ram_dout   = (issue && we_q) ? wdata_q[8*cnt_q +: 8] : 8'h00;
  assign resp_valid = resp_fire ? (NCH'(1) << ch_q) : '0;
  assign resp_data  = (resp_fire && !we_q) ? ext : '0;

  // Next-state and byte counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MC_IDLE: begin
        if (go) begin
          state_d = MC_XFER;
          cnt_d   = 2'd0;
        end
      end
      MC_XFER: begin
        if (cancel) begin
          state_d = MC_IDLE;
        end else if (issue) begin
          cnt_d = cnt_q + 2'd1;
          if (last) state_d = we_q ? MC_DONE : MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (cancel) state_d = MC_IDLE;
        else if (rdy) state_d = MC_DONE;
      end
      default: begin
        if (cancel || rdy) state_d = MC_IDLE;
      end
    endcase
  end

  // Extend the assembled read data from its top byte.
  always_comb begin
    ext = data_q;
    case (size_q)
      MEM_SIZE_B: ext = {{(XLEN-8){signed_q & data_q[7]}}, data_q[7:0]};
      MEM_SIZE_H: ext = {{(XLEN-16){signed_q & data_q[15]}}, data_q[15:0]};
      default:    ext = data_q;
    endcase
  end

  // State, latched request and read assembly; a pending capture is taken even when rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MC_IDLE;
      rr_ptr_q   <= '0;
      ch_q       <= '0;
      we_q       <= 1'b0;
      keep_q     <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'd0;
      cnt_q      <= 2'd0;
      cap_pend_q <= 1'b0;
      cap_idx_q  <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_pend_q <= issue && !we_q;
      cap_idx_q  <= cnt_q;
      if (cap_pend_q) data_q[8*cap_idx_q +: 8] <= ram_din;
      if (go) begin
        ch_q     <= arb_idx;
        rr_ptr_q <= (arb_idx == PW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
        we_q     <= req_we[arb_idx];
        keep_q   <= req_keep[arb_idx];
        signed_q <= req_signed[arb_idx];
        size_q   <= req_size[2*arb_idx +: 2];
        addr_q   <= req_addr[arb_idx*XLEN +: XLEN];
        wdata_q  <= req_wdata[arb_idx*XLEN +: XLEN];
        data_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_memory_controller.sv
// Bench for multi_port_memory_controller: directed scenarios followed by random
// single-channel transfers checked against a byte-level transaction model.
module tb_multi_port_memory_controller;

  localparam int NCH  = 3;
  localparam int XLEN = 32;

  logic                clk = 1'b0, rst = 1'b1, rdy = 1'b0, flush = 1'b0, io_buffer_full = 1'b0;
  logic [NCH-1:0]      req_valid = '0, req_keep = '0, req_we = '0, req_signed = '0;
  logic [2*NCH-1:0]    req_size = '0;
  logic [XLEN*NCH-1:0] req_addr = '0, req_wdata = '0;
  logic [NCH-1:0]      req_ready, resp_valid;
  logic [XLEN-1:0]     resp_data, ram_addr;
  logic                busy, ram_wr;
  logic [7:0]          ram_din = 8'h00, ram_dout;

  logic [7:0] mem [logic [31:0]];
  int n_assert = 0;
  int n_fail   = 0;
  int grants[$];

  always #5 clk = ~clk;

  multi_port_memory_controller #(
    .NCH   (NCH),
    .XLEN  (XLEN),
    .IO_HI (2'b11)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .req_valid      (req_valid),
    .req_keep       (req_keep),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .busy           (busy),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_addr       (ram_addr),
    .ram_wr         (ram_wr)
  );

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Byte RAM: read data shows the byte addressed in the previous cycle.
  always @(posedge clk) begin
    ram_din <= mem_rd(ram_addr);
    if (ram_wr) mem[ram_addr] = ram_dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int c);
    return 32'd1 << c;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // Little-endian value of n bytes, sign-extended arithmetically when requested.
  function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v + (32'(mem_rd(a + 32'(i))) << (8 * i));
    if (sgn && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic set_req(input int ch, input bit we, input logic [1:0] size, input bit sgn,
                         input bit keep, input logic [31:0] addr, input logic [31:0] wdata);
    req_we[ch]             = we;
    req_size[2*ch +: 2]    = size;
    req_signed[ch]         = sgn;
    req_keep[ch]           = keep;
    req_addr[32*ch +: 32]  = addr;
    req_wdata[32*ch +: 32] = wdata;
  endtask

  // One transfer on one channel; every cycle is checked against the rdy-cycle count model.
  task automatic run_txn(input int ch, input bit we, input logic [1:0] size, input bit sgn,
                         input bit keep, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit rand_rdy, input int flush_at,
                         output logic [31:0] data, output int resp_cyc);
    int n, k;
    bit r, granted, done, exp_issue, exp_resp;
    logic [31:0] exp_data;
    n        = nbytes(size);
    exp_data = we ? 32'd0 : model_read(addr, n, sgn);
    data     = 32'hDEAD_BEEF;
    resp_cyc = -1;
    @(posedge clk); #1;
    set_req(ch, we, size, sgn, keep, addr, wdata);
    req_valid[ch] = 1'b1;
    granted = 1'b0;
    for (int w = 0; w < 50 && !granted; w++) begin
      if (w > 0) begin @(posedge clk); #1; end
      r   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy = r;
      @(negedge clk);
      check("req_ready", 32'(req_ready), r ? oh(ch) : 32'd0);
      if (req_ready[ch]) granted = 1'b1;
    end
    check("grant_seen", 32'(granted), 32'd1);
    k    = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 80 && !done && granted; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) req_valid[ch] = 1'b0;
      r     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy   = r;
      flush = (cyc == flush_at);
      @(negedge clk);
      if (r) k++;
      exp_issue = r && (k <= n);
      exp_resp  = r && (k == (we ? n + 1 : n + 2));
      check("busy", 32'(busy), 32'd1);
      check("ram_addr", ram_addr, exp_issue ? addr + 32'(k - 1) : 32'd0);
      check("ram_wr", 32'(ram_wr), 32'(exp_issue && we));
      if (we) check("ram_dout", 32'(ram_dout), exp_issue ? 32'(wdata[8*(k-1) +: 8]) : 32'd0);
      check("resp_valid", 32'(resp_valid), exp_resp ? oh(ch) : 32'd0);
      if (exp_resp) begin
        check("resp_data", resp_data, exp_data);
        data     = resp_data;
        resp_cyc = cyc;
        done     = 1'b1;
      end
    end
    check("txn_done", 32'(done), 32'd1);
    flush = 1'b0;
  endtask

  // Raise the channels in mask and record the order in which they are accepted.
  task automatic collect_grants(input logic [NCH-1:0] mask, input int count);
    int drop;
    drop = -1;
    grants.delete();
    @(posedge clk); #1;
    rdy       = 1'b1;
    req_valid = req_valid | mask;
    for (int cyc = 0; cyc < 100 && grants.size() < count; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (req_ready[c]) begin
        grants.push_back(c);
        drop = c;
      end
      @(posedge clk); #1;
      if (drop >= 0) req_valid[drop] = 1'b0;
      drop = -1;
    end
    check("grant_count", 32'(grants.size()), 32'(count));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int cyc = 0; cyc < 60 && !idle; cyc++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    check("wait_idle", 32'(idle), 32'd1);
  endtask

  // Uncommitted word read of 0x100 on ch0 with a one-cycle flush in cycle 'at'.
  task automatic flush_read(input int at);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'd0);
    req_valid[0] = 1'b1;
    rdy          = 1'b1;
    @(negedge clk);
    check("fl_ready", 32'(req_ready), 32'd1);
    for (int cyc = 1; cyc <= at + 3; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) req_valid[0] = 1'b0;
      flush = (cyc == at);
      @(negedge clk);
      check("fl_resp", 32'(resp_valid), 32'd0);
      if (cyc < at) check("fl_busy", 32'(busy), 32'd1);
      if (cyc == at + 1) check("fl_idle", 32'(busy), 32'd0);
    end
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] d, addr;
    int rc, first, wr_seen, ch1_g, resp0;
    bit we, sgn, keep;
    logic [1:0] size;
    int ch, fl;

    for (int i = 0; i < 1024; i++) mem[32'(i)] = 8'($urandom);
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h200] = 8'h80;
    mem[32'h210] = 8'h01; mem[32'h211] = 8'h80;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset asserted in the middle of a word read
    @(posedge clk); #1;
    set_req(2, 1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'd0);
    req_valid[2] = 1'b1;
    rdy          = 1'b1;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("t1_xfer_addr", ram_addr, 32'h100);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_ram_wr", 32'(ram_wr), 32'd0);
    check("t1_ram_addr", ram_addr, 32'd0);
    check("t1_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("t1_busy_next", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word read timing and little-endian assembly
    run_txn(0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 0, d, rc);
    check("t2_data", d, 32'h4433_2211);
    check("t2_resp_cycle", 32'(rc), 32'd6);

    // Round-robin from reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h40, 32'h5A);
    set_req(2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h200, 32'd0);
    collect_grants(3'b111, 3);
    if (grants.size() == 3) begin
      check("t4_g0", 32'(grants[0]), 32'd0);
      check("t4_g1", 32'(grants[1]), 32'd1);
      check("t4_g2", 32'(grants[2]), 32'd2);
    end
    wait_idle();
    check("t4_wrote", 32'(mem_rd(32'h40)), 32'h5A);
    collect_grants(3'b101, 2);
    if (grants.size() == 2) begin
      check("t4_rg0", 32'(grants[0]), 32'd0);
      check("t4_rg1", 32'(grants[1]), 32'd2);
    end
    wait_idle();

    // Extension of byte and half reads
    run_txn(0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 0, d, rc);
    check("t3_byte_s", d, 32'hFFFF_FF80);
    run_txn(0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h200, 32'd0, 1'b0, 0, d, rc);
    check("t3_byte_u", d, 32'h0000_0080);
    run_txn(0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h210, 32'd0, 1'b0, 0, d, rc);
    check("t3_half_s", d, 32'hFFFF_8001);

    // IO write held back by a full UART buffer while ch0 is served
    @(posedge clk); #1;
    io_buffer_full = 1'b1;
    set_req(1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h30000, 32'hA5);
    set_req(0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'd0);
    req_valid[1:0] = 2'b11;
    rdy            = 1'b1;
    first = -1; wr_seen = 0; ch1_g = 0; resp0 = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (first == 0) req_valid[0] = 1'b0;
      end
      @(negedge clk);
      if (ram_wr) wr_seen++;
      if (req_ready[1]) ch1_g++;
      if (first < 0) for (int c = 0; c < NCH; c++) if (req_ready[c]) first = c;
      if (resp_valid[0]) resp0++;
    end
    req_valid[1]   = 1'b0;
    io_buffer_full = 1'b0;
    check("t5_first", 32'(first), 32'd0);
    check("t5_no_wr", 32'(wr_seen), 32'd0);
    check("t5_ch1_blocked", 32'(ch1_g), 32'd0);
    check("t5_ch0_resp", 32'(resp0), 32'd1);
    run_txn(1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h30000, 32'hA5, 1'b0, 0, d, rc);
    check("t5_io_byte", 32'(mem_rd(32'h30000)), 32'hA5);

    // Flush cancels an uncommitted read, including in its response cycle
    flush_read(2);
    flush_read(6);

    // Flush ignored for a committed half write
    run_txn(1, 1'b1, 2'd1, 1'b0, 1'b1, 32'h120, 32'h0000_BEEF, 1'b0, 2, d, rc);
    check("t6_wr_lo", 32'(mem_rd(32'h120)), 32'hEF);
    check("t6_wr_hi", 32'(mem_rd(32'h121)), 32'hBE);

    // Word read with rdy toggling
    run_txn(0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'd0, 1'b1, 0, d, rc);
    check("t6_rdy_data", d, 32'h4433_2211);

    // Random single-channel transfers
    for (int t = 0; t < 40; t++) begin
      ch   = $urandom_range(0, NCH - 1);
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      keep = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
      fl   = (we || keep) ? $urandom_range(1, 6) : 0;
      run_txn(ch, we, size, sgn, keep, addr, $urandom, 1'b1, fl, d, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
